// File: rtl/cpu_defs.sv
// Shared definitions for the multi-cycle CPU control path:
// opcodes, FSM state encodings and datapath select codes.
package cpu_defs;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   localparam logic [3:0] S_FETCH     = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_MEM_ADDR  = 4'd2;
   localparam logic [3:0] S_MEM_RD    = 4'd3;
   localparam logic [3:0] S_MEM_WB    = 4'd4;
   localparam logic [3:0] S_MEM_WR    = 4'd5;
   localparam logic [3:0] S_R_EXEC    = 4'd6;
   localparam logic [3:0] S_R_WB      = 4'd7;
   localparam logic [3:0] S_BRANCH    = 4'd8;
   localparam logic [3:0] S_JUMP      = 4'd9;
   localparam logic [3:0] S_ADDI_EXEC = 4'd10;
   localparam logic [3:0] S_ADDI_WB   = 4'd11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] ASB_REGB = 2'b00;
   localparam logic [1:0] ASB_ONE  = 2'b01;
   localparam logic [1:0] ASB_IMM  = 2'b10;
   localparam logic [1:0] ASB_BOFF = 2'b11;

endpackage

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle CPU.
// Sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath controls.
module multicycle_control_fsm
   import cpu_defs::*;
#(
   parameter int OPCODE_WIDTH = 6,
   parameter int STATE_WIDTH  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic                    mem_ready,
   output logic                    IorD,
   output logic                    MemRead,
   output logic                    MemWrite,
   output logic                    IRWrite,
   output logic                    PCWrite,
   output logic                    PCWriteCond,
   output logic [1:0]              PCSource,
   output logic                    ALUSrcA,
   output logic [1:0]              ALUSrcB,
   output logic [1:0]              ALUOp,
   output logic                    RegDst,
   output logic                    MemtoReg,
   output logic                    RegWrite,
   output logic                    illegal_op,
   output logic [STATE_WIDTH-1:0]  state_dbg
);

   logic [STATE_WIDTH-1:0] state_q;
   logic [STATE_WIDTH-1:0] state_d;

   assign state_dbg = state_q;

   // State register; synchronous reset aborts any instruction in flight.
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= S_FETCH;
      else
         state_q <= state_d;
   end

   // Next-state and output decode; all outputs forced low during reset.
   always_comb begin
      state_d     = S_FETCH;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      PCSource    = PCSRC_ALU;
      ALUSrcA     = 1'b0;
      ALUSrcB     = ASB_REGB;
      ALUOp       = ALUOP_ADD;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      illegal_op  = 1'b0;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = ASB_ONE;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
               state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
               ALUSrcB = ASB_BOFF;
               case (opcode)
                  OP_LW, OP_SW: state_d = S_MEM_ADDR;
                  OP_RTYPE:     state_d = S_R_EXEC;
                  OP_BEQ:       state_d = S_BRANCH;
                  OP_J:         state_d = S_JUMP;
                  OP_ADDI:      state_d = S_ADDI_EXEC;
                  default: begin
                     state_d    = S_FETCH;
                     illegal_op = 1'b1;
                  end
               endcase
            end
            S_MEM_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = ASB_IMM;
               state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
               IorD    = 1'b1;
               MemRead = 1'b1;
               state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
               MemtoReg = 1'b1;
               RegWrite = 1'b1;
            end
            S_MEM_WR: begin
               IorD     = 1'b1;
               MemWrite = 1'b1;
               state_d  = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_R_EXEC: begin
               ALUSrcA = 1'b1;
               ALUOp   = ALUOP_FUNCT;
               state_d = S_R_WB;
            end
            S_R_WB: begin
               RegDst   = 1'b1;
               RegWrite = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = ALUOP_SUB;
               PCWriteCond = 1'b1;
               PCSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
               PCWrite  = 1'b1;
               PCSource = PCSRC_JUMP;
            end
            S_ADDI_EXEC: begin
               ALUSrcA = 1'b1;
               ALUSrcB = ASB_IMM;
               state_d = S_ADDI_WB;
            end
            S_ADDI_WB: begin
               RegWrite = 1'b1;
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: directed vectors
// push expected state/outputs, a negedge monitor pops and compares.
module tb_multicycle_control_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
   logic [1:0] PCSource, ALUSrcB, ALUOp;
   logic       ALUSrcA, RegDst, MemtoReg, RegWrite, illegal_op;
   logic [3:0] state_dbg;

   int nvec = 0;
   int nmis = 0;
   logic [20:0] expq[$];

   always #5 clk = ~clk;

   multicycle_control_fsm dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .illegal_op(illegal_op), .state_dbg(state_dbg)
   );

   // Packed layout: st ill iord mr mw irw pcw pcwc pcs asa asb aop rd m2r rw
   function automatic logic [20:0] v(
      input logic [3:0] st, input logic ill, input logic iord,
      input logic mr, input logic mw, input logic irw, input logic pcw,
      input logic pcwc, input logic [1:0] pcs, input logic asa,
      input logic [1:0] asb, input logic [1:0] aop, input logic rd,
      input logic m2r, input logic rw);
      return {st, ill, iord, mr, mw, irw, pcw, pcwc, pcs, asa, asb, aop,
              rd, m2r, rw};
   endfunction

   wire [20:0] act = {state_dbg, illegal_op, IorD, MemRead, MemWrite,
                      IRWrite, PCWrite, PCWriteCond, PCSource, ALUSrcA,
                      ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite};

   // Hand-derived expected vectors per state/condition
   logic [20:0] E_RST0, E_FW, E_FR, E_DEC, E_ILL, E_MADDR, E_MRD, E_MWB;
   logic [20:0] E_MWR, E_REX, E_RWB, E_BR, E_J, E_AEX, E_AWB, E_RST3;

   initial begin
      //         st    il io mr mw ir pw pc pcs   a  asb   aop   rd m2 rw
      E_RST0  = v(4'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
      E_FW    = v(4'd0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0);
      E_FR    = v(4'd0, 0, 0, 1, 0, 1, 1, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0);
      E_DEC   = v(4'd1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, 0, 0);
      E_ILL   = v(4'd1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, 0, 0);
      E_MADDR = v(4'd2, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0);
      E_MRD   = v(4'd3, 0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
      E_MWB   = v(4'd4, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 1);
      E_MWR   = v(4'd5, 0, 1, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
      E_REX   = v(4'd6, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 0, 0, 0);
      E_RWB   = v(4'd7, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 1);
      E_BR    = v(4'd8, 0, 0, 0, 0, 0, 0, 1, 2'b01, 1, 2'b00, 2'b01, 0, 0, 0);
      E_J     = v(4'd9, 0, 0, 0, 0, 0, 1, 0, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0);
      E_AEX   = v(4'd10,0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0);
      E_AWB   = v(4'd11,0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 1);
      E_RST3  = v(4'd3, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
   end

   // Apply one cycle of inputs and queue the response expected this cycle
   task automatic step(input logic r, input logic [5:0] op,
                       input logic rdy, input logic [20:0] e);
      reset     = r;
      opcode    = op;
      mem_ready = rdy;
      expq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: pop and compare mid-cycle, away from the active edge
   always @(negedge clk) begin
      if (expq.size() > 0) begin
         logic [20:0] e;
         e = expq.pop_front();
         nvec++;
         if (act !== e) begin
            nmis++;
            $display("FAIL vec%0d: got st=%0d bits=%b, need st=%0d bits=%b",
                     nvec, act[20:17], act[16:0], e[20:17], e[16:0]);
         end
      end
   end

   initial begin
      reset     = 1'b1;
      opcode    = 6'h00;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      // Reset held: FETCH with everything low
      step(1, 6'h00, 1, E_RST0);
      // Fetch waits three cycles, completes on the fourth
      step(0, 6'h23, 0, E_FW);
      step(0, 6'h23, 0, E_FW);
      step(0, 6'h23, 0, E_FW);
      step(0, 6'h23, 1, E_FR);
      // LW: 1,2,3,4 then back to fetch
      step(0, 6'h23, 1, E_DEC);
      step(0, 6'h23, 1, E_MADDR);
      step(0, 6'h23, 1, E_MRD);
      step(0, 6'h23, 1, E_MWB);
      step(0, 6'h2B, 1, E_FR);
      // SW with two wait cycles in MEM_WR
      step(0, 6'h2B, 1, E_DEC);
      step(0, 6'h2B, 1, E_MADDR);
      step(0, 6'h2B, 0, E_MWR);
      step(0, 6'h2B, 0, E_MWR);
      step(0, 6'h2B, 1, E_MWR);
      step(0, 6'h04, 1, E_FR);
      // BEQ
      step(0, 6'h04, 1, E_DEC);
      step(0, 6'h04, 1, E_BR);
      step(0, 6'h02, 1, E_FR);
      // J
      step(0, 6'h02, 1, E_DEC);
      step(0, 6'h02, 1, E_J);
      step(0, 6'h00, 1, E_FR);
      // R-type
      step(0, 6'h00, 1, E_DEC);
      step(0, 6'h00, 1, E_REX);
      step(0, 6'h00, 1, E_RWB);
      step(0, 6'h08, 1, E_FR);
      // ADDI
      step(0, 6'h08, 1, E_DEC);
      step(0, 6'h08, 1, E_AEX);
      step(0, 6'h08, 1, E_AWB);
      step(0, 6'h3F, 1, E_FR);
      // Illegal opcode: pulse in DECODE, back to FETCH
      step(0, 6'h3F, 1, E_ILL);
      step(0, 6'h23, 1, E_FR);
      // LW aborted by reset while in MEM_RD
      step(0, 6'h23, 1, E_DEC);
      step(0, 6'h23, 1, E_MADDR);
      step(0, 6'h23, 0, E_MRD);
      step(1, 6'h23, 1, E_RST3);
      step(0, 6'h23, 0, E_FW);
      step(0, 6'h23, 1, E_FR);
      @(negedge clk);
      #1;
      if (expq.size() != 0) begin
         nmis++;
         $display("FAIL drain: %0d left, need 0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
